// File: rtl/spart_pkg.sv
// Shared bus decode constants and status layout for the SPART register interface.
package spart_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'b00,
        ADDR_STATUS = 2'b01,
        ADDR_DBL    = 2'b10,
        ADDR_DBH    = 2'b11
    } spart_addr_e;

    localparam int ST_TBR   = 0;
    localparam int ST_RDA   = 1;
    localparam int ST_RXOVR = 2;
    localparam int ST_TXOVR = 3;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'h0516;

    function automatic logic [7:0] status_byte(input logic tbr, input logic rda,
                                               input logic rx_ovr, input logic tx_ovr);
        logic [7:0] s;
        s           = '0;
        s[ST_TBR]   = tbr;
        s[ST_RDA]   = rda;
        s[ST_RXOVR] = rx_ovr;
        s[ST_TXOVR] = tx_ovr;
        return s;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// 16x baud enable generator: reloadable down-counter, enable registered for a clean pulse.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int unsigned      DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             brg_en
);

    // Divisors of 0 and 1 both park the counter at zero so the enable stays high.
    function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
        return (d <= DIV_W'(1)) ? '0 : d - DIV_W'(1);
    endfunction

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic             brg_en_reg;

    always_comb begin
        cnt_next = cnt_reg - DIV_W'(1);
        if (load || (cnt_reg == '0)) begin
            cnt_next = reload_val(div);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= reload_val(DIV_RESET);
            brg_en_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            brg_en_reg <= (cnt_next == '0);
        end
    end

    assign brg_en = brg_en_reg;

endmodule

// File: rtl/spart_bus_if.sv
// SPART register-side bus responder: decode, TX holding / RX buffer, status and divisor.
module spart_bus_if
    import spart_pkg::*;
#(
    parameter int unsigned      DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_RESET_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       brg_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    logic             tbr_reg, tbr_next;
    logic             rda_reg, rda_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic [7:0]       rx_buf_reg, rx_buf_next;
    logic             tx_ovr_reg, tx_ovr_next;
    logic             rx_ovr_reg, rx_ovr_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             div_load;
    logic [7:0]       rd_byte;

    logic rd_cyc, wr_cyc, rd_data, rd_status, wr_data, wr_dbl, wr_dbh;

    assign rd_cyc    = iocs && iorw;
    assign wr_cyc    = iocs && !iorw;
    assign rd_data   = rd_cyc && (ioaddr == ADDR_DATA);
    assign rd_status = rd_cyc && (ioaddr == ADDR_STATUS);
    assign wr_data   = wr_cyc && (ioaddr == ADDR_DATA);
    assign wr_dbl    = wr_cyc && (ioaddr == ADDR_DBL);
    assign wr_dbh    = wr_cyc && (ioaddr == ADDR_DBH);

    always_comb begin
        tbr_next     = tbr_reg;
        tx_data_next = tx_data_reg;
        // Acceptance looks at the pre-edge tbr, so a write racing a handoff is dropped.
        if (wr_data && tbr_reg) begin
            tx_data_next = databus;
            tbr_next     = 1'b0;
        end else if (!tbr_reg && tx_ready) begin
            tbr_next = 1'b1;
        end
        tx_ovr_next = (wr_data && !tbr_reg) || (tx_ovr_reg && !rd_status);

        rda_next    = rda_reg;
        rx_buf_next = rx_buf_reg;
        if (rx_valid) begin
            rx_buf_next = rx_data;
            rda_next    = 1'b1;
        end else if (rd_data) begin
            rda_next = 1'b0;
        end
        rx_ovr_next = (rx_valid && rda_reg && !rd_data) || (rx_ovr_reg && !rd_status);

        div_next = div_reg;
        div_load = wr_dbl || wr_dbh;
        if (wr_dbl) div_next[7:0]       = databus;
        if (wr_dbh) div_next[DIV_W-1:8] = databus[DIV_W-9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbr_reg     <= 1'b1;
            rda_reg     <= 1'b0;
            tx_data_reg <= '0;
            rx_buf_reg  <= '0;
            tx_ovr_reg  <= 1'b0;
            rx_ovr_reg  <= 1'b0;
            div_reg     <= DIV_RESET;
        end else begin
            tbr_reg     <= tbr_next;
            rda_reg     <= rda_next;
            tx_data_reg <= tx_data_next;
            rx_buf_reg  <= rx_buf_next;
            tx_ovr_reg  <= tx_ovr_next;
            rx_ovr_reg  <= rx_ovr_next;
            div_reg     <= div_next;
        end
    end

    always_comb begin
        rd_byte = '0;
        case (ioaddr)
            ADDR_DATA:   rd_byte = rx_buf_reg;
            ADDR_STATUS: rd_byte = status_byte(tbr_reg, rda_reg, rx_ovr_reg, tx_ovr_reg);
            ADDR_DBL:    rd_byte = div_reg[7:0];
            ADDR_DBH:    rd_byte = 8'(div_reg >> 8);
            default:     rd_byte = '0;
        endcase
    end

    // Gated by rst_n so the bus lets go the instant reset asserts.
    assign databus = (rst_n && rd_cyc) ? rd_byte : 8'bz;

    spart_baud_gen #(
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .div    (div_next),
        .load   (div_load),
        .brg_en (brg_en)
    );

    assign tbr      = tbr_reg;
    assign rda      = rda_reg;
    assign tx_data  = tx_data_reg;
    assign tx_valid = ~tbr_reg;

endmodule

// File: tb/tb_spart_bus_if.sv
// Directed and randomized checks of spart_bus_if against a cycle-level register model.
module tb_spart_bus_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] tb_wd = 8'h00;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    wire  [7:0] databus;
    wire        rda, tbr, brg_en, tx_valid;
    wire  [7:0] tx_data;

    assign databus = (iocs && !iorw) ? tb_wd : 8'bz;

    // Weak pull-ups make a released bus read back as 0xFF.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pu
            pullup pu (databus[gi]);
        end
    endgenerate

    always #5 clk = ~clk;

    spart_bus_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .brg_en   (brg_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic       m_tbr, m_rda, m_rxovr, m_txovr;
    logic [7:0] m_txd, m_rxbuf;
    int         m_div;
    int         m_since;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tbr = 1'b1; m_rda = 1'b0; m_rxovr = 1'b0; m_txovr = 1'b0;
        m_txd = 8'h00; m_rxbuf = 8'h00; m_div = 16'h0516; m_since = 0;
    endtask

    function automatic logic [7:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_rxbuf;
            2'd1:    return {4'b0, m_txovr, m_rxovr, m_rda, m_tbr};
            2'd2:    return 8'(m_div % 256);
            default: return 8'(m_div / 256);
        endcase
    endfunction

    // Enable expected when the cycles elapsed since the last reload hit divisor-1 mod divisor.
    function automatic logic exp_brg();
        if (!rst_n) return 1'b0;
        if (m_div <= 1) return 1'b1;
        return ((m_since % m_div) == (m_div - 1));
    endfunction

    task automatic model_edge();
        bit rd0, rdst, wr0;
        logic [7:0] wd;
        rd0  = iocs && iorw && (ioaddr == 2'd0);
        rdst = iocs && iorw && (ioaddr == 2'd1);
        wr0  = iocs && !iorw && (ioaddr == 2'd0);
        wd   = tb_wd;
        m_txovr = (wr0 && !m_tbr) || (m_txovr && !rdst);
        m_rxovr = (rx_valid && m_rda && !rd0) || (m_rxovr && !rdst);
        if (wr0 && m_tbr) begin
            m_txd = wd;
            m_tbr = 1'b0;
        end else if (!m_tbr && tx_ready) begin
            m_tbr = 1'b1;
        end
        if (rx_valid) begin
            m_rxbuf = rx_data;
            m_rda   = 1'b1;
        end else if (rd0) begin
            m_rda = 1'b0;
        end
        if (iocs && !iorw && ioaddr[1]) begin
            if (ioaddr[0]) m_div = (m_div % 256) + 256 * int'(wd);
            else           m_div = (m_div / 256) * 256 + int'(wd);
            m_since = 0;
        end else begin
            m_since++;
        end
    endtask

    task automatic check_all();
        chk("tbr", 16'(tbr), 16'(m_tbr));
        chk("tx_valid", 16'(tx_valid), 16'(!m_tbr));
        chk("tx_data", 16'(tx_data), 16'(m_txd));
        chk("rda", 16'(rda), 16'(m_rda));
        chk("brg_en", 16'(brg_en), 16'(exp_brg()));
        if (rst_n && iocs && iorw) chk("rd_data", 16'(databus), 16'(exp_rd(ioaddr)));
        else if (!iocs)            chk("bus_z", 16'(databus), 16'h00FF);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic setb(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd);
        iocs = cs; iorw = rw; ioaddr = a; tb_wd = wd;
    endtask

    task automatic idle();
        setb(1'b0, 1'b0, 2'd0, 8'h00);
        rx_valid = 1'b0;
    endtask

    int last_pulse, gap, r;

    initial begin
        model_reset();
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;

        // Divisor 10 and readback
        setb(1'b1, 1'b0, 2'd2, 8'h0A); cyc();
        setb(1'b1, 1'b0, 2'd3, 8'h00); cyc();
        setb(1'b1, 1'b1, 2'd2, 8'h00); cyc();
        chk("dbl_read", 16'(m_div % 256), 16'h000A);
        setb(1'b1, 1'b1, 2'd3, 8'h00); cyc();
        idle();
        last_pulse = -1;
        gap = -1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (brg_en) begin
                if (last_pulse >= 0 && gap < 0) gap = i - last_pulse;
                last_pulse = i;
            end
        end
        chk("brg_period", 16'(gap), 16'd10);

        // TX handoff
        tx_ready = 1'b1;
        setb(1'b1, 1'b0, 2'd0, 8'h41); cyc();
        idle(); cyc();
        cyc();
        tx_ready = 1'b0;

        // TX overrun and sticky clear on status read
        setb(1'b1, 1'b0, 2'd0, 8'h42); cyc();
        setb(1'b1, 1'b0, 2'd0, 8'h43); cyc();
        idle(); cyc();
        chk("tx_hold_first", 16'(tx_data), 16'h0042);
        setb(1'b1, 1'b1, 2'd1, 8'h00); cyc();
        setb(1'b1, 1'b1, 2'd1, 8'h00); cyc();
        idle(); tx_ready = 1'b1; cyc();
        tx_ready = 1'b0;

        // RX path
        rx_data = 8'h5A; rx_valid = 1'b1; cyc();
        rx_valid = 1'b0;
        setb(1'b1, 1'b1, 2'd0, 8'h00); cyc();
        setb(1'b1, 1'b0, 2'd1, 8'hFF); cyc();
        idle(); cyc();
        rx_data = 8'h11; rx_valid = 1'b1; cyc();
        rx_data = 8'h22; cyc();
        rx_valid = 1'b0;
        setb(1'b1, 1'b1, 2'd0, 8'h00); cyc();
        chk("rx_last_byte", 16'(m_rxbuf), 16'h0022);
        rx_data = 8'h33; rx_valid = 1'b1; cyc();
        rx_data = 8'h44; cyc();
        rx_valid = 1'b0;
        setb(1'b1, 1'b1, 2'd1, 8'h00); cyc();
        setb(1'b1, 1'b1, 2'd0, 8'h00); cyc();
        idle(); cyc();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    setb(1'b1, 1'b0, 2'd0, 8'($urandom));
                2, 3:    setb(1'b1, 1'b1, 2'd0, 8'h00);
                4:       setb(1'b1, 1'b1, 2'd1, 8'h00);
                5:       setb(1'b1, 1'b0, 2'd2, 8'($urandom_range(0, 12)));
                6:       setb(1'b1, 1'b0, 2'd3, 8'h00);
                7:       setb(1'b1, 1'b0, 2'd1, 8'($urandom));
                8:       setb(1'b1, 1'b1, 2'($urandom_range(2, 3)), 8'h00);
                default: setb(1'b0, 1'b0, 2'd0, 8'h00);
            endcase
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            cyc();
        end
        idle();
        tx_ready = 1'b0;
        cyc();

        // Reset mid-transmit and mid-read
        if (!m_tbr) begin
            tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
        end
        setb(1'b1, 1'b0, 2'd0, 8'h77); cyc();
        idle(); rx_data = 8'h66; rx_valid = 1'b1; cyc();
        rx_valid = 1'b0;
        setb(1'b1, 1'b1, 2'd2, 8'h00);
        @(negedge clk);
        check_all();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_bus_z", 16'(databus), 16'h00FF);
        chk("rst_tbr", 16'(tbr), 16'd1);
        chk("rst_rda", 16'(rda), 16'd0);
        chk("rst_tx_valid", 16'(tx_valid), 16'd0);
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        setb(1'b1, 1'b1, 2'd2, 8'h00); cyc();
        setb(1'b1, 1'b1, 2'd3, 8'h00); cyc();
        idle(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
